// File: rtl/pipe_pkg.sv
// Shared types for the core pipeline: stage-boundary payload structs and the elastic
// stage occupancy state.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_state_e;

  // Decode-stage control bundle, 12 bits.
  typedef struct packed {
    logic       jmp_sel;
    logic       br_unsigned;
    logic       reg_write;
    logic       mem_write;
    logic       src_a;
    logic       src_b;
    logic [1:0] wb_sel;
    logic [3:0] alu_control;
  } de_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_payload_t;

  // ID/EX boundary: 12 + 4*32 + 4*5 + 3 = 163 bits.
  typedef struct packed {
    de_ctrl_t    ctrl;
    logic [31:0] immediate;
    logic [31:0] pc;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
  } de_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] rs2data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } em_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
  } mw_payload_t;

  localparam int unsigned FD_PAYLOAD_W = $bits(fd_payload_t);
  localparam int unsigned DE_PAYLOAD_W = $bits(de_payload_t);
  localparam int unsigned EM_PAYLOAD_W = $bits(em_payload_t);
  localparam int unsigned MW_PAYLOAD_W = $bits(mw_payload_t);

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage entry of an elastic stage: payload flops plus a valid bit.
// Flush beats load, load beats drop.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = DE_PAYLOAD_W,
  parameter bit          CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      if (CLEAR_PAYLOAD) begin
        data_d = '0;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Valid/ready pipeline stage with optional skid entry (registered in_ready_o) and flush.
// The main slot always drives the outputs; the skid slot only absorbs the beat in flight.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = DE_PAYLOAD_W,
  parameter bit          SKID_EN       = 1'b1,
  parameter bit          CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic              killed_o
);

  stage_state_e      state_q, state_d;
  logic              in_fire, out_fire;
  logic              main_load, main_drop, main_from_skid;
  logic              skid_load, skid_drop;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_din, main_data, skid_data;
  logic              killed_q, killed_d;
  logic              rst_done_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = main_valid & out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire && SKID_EN) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d   = ST_EMPTY;
          main_drop = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
  end

  // A flush kills anything held that is not leaving this cycle, plus any beat accepted now.
  always_comb begin
    killed_d = flush_i & (in_fire | (state_q == ST_FULL) | ((state_q == ST_ONE) & ~out_fire));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      killed_q   <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      killed_q   <= killed_d;
      rst_done_q <= 1'b1;
    end
  end

  assign main_din = main_from_skid ? skid_data : in_data_i;

  pipe_skid_slot #(
    .DATA_W        (DATA_W),
    .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  if (SKID_EN) begin : g_skid
    logic in_ready_q;

    pipe_skid_slot #(
      .DATA_W        (DATA_W),
      .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .data_i  (in_data_i),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );

    // rst_done_q gates one extra edge so ready rises on the second edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        in_ready_q <= 1'b0;
      end else begin
        in_ready_q <= rst_done_q & (state_d != ST_FULL);
      end
    end

    assign in_ready_o = in_ready_q;
  end else begin : g_no_skid
    logic ready_en_q;
    logic unused_skid;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ready_en_q <= 1'b0;
      end else begin
        ready_en_q <= rst_done_q;
      end
    end

    assign in_ready_o  = ready_en_q & (~main_valid | out_ready_i);
    assign skid_valid  = 1'b0;
    assign skid_data   = '0;
    assign unused_skid = ^{skid_load, skid_drop};
  end

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
  assign killed_o    = killed_q;

endmodule
